cla_adder_pipe: RTL

//  Parametrised two-level carry-lookahead adder/subtractor with a 2-stage pipeline and valid/ready

---
 rtl/cla_adder_pipe_pkg.sv | 12 +
 rtl/cla_adder_pipe_cla4.sv | 19 +
 rtl/cla_adder_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cla_adder_pipe_pkg.sv
// rtl/cla_adder_pipe_pkg.sv - shared constants and width legality check for the CLA adder pipeline
package cla_adder_pipe_pkg;

  localparam int   GRP    = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit width_legal(input int w);
    return (w >= GRP) && (w <= 64) && ((w % GRP) == 0);
  endfunction

endpackage

// File: rtl/cla_adder_pipe_cla4.sv
// rtl/cla_adder_pipe_cla4.sv - combinational 4-bit carry-lookahead unit
module cla4_unit (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [4:1] c,
  output logic       grp_g,
  output logic       grp_p
);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = grp_g | (grp_p & cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined two-level CLA adder/subtractor with valid/ready
module cla_adder_pipe
  import cla_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = WIDTH / GRP;

  if (!width_legal(WIDTH)) begin : g_width_bad
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  logic s1_valid, s1_adv, s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;

  // Stage 1: per-bit generate/propagate and group G/P
  logic [WIDTH-1:0]          bb, g_in, p_in;
  logic                      c0_in;
  logic [NGRP-1:0]           gg_in, gp_in;
  logic [NGRP-1:0][4:1]      unused_s1_c;

  assign bb    = (op == OP_SUB) ? ~b : b;
  assign c0_in = (op == OP_ADD) ? cin : 1'b1;
  assign g_in  = a & bb;
  assign p_in  = a ^ bb;

  for (genvar k = 0; k < NGRP; k++) begin : g_s1
    cla4_unit u_cla4 (
      .g     (g_in[GRP*k +: GRP]),
      .p     (p_in[GRP*k +: GRP]),
      .cin   (1'b0),
      .c     (unused_s1_c[k]),
      .grp_g (gg_in[k]),
      .grp_p (gp_in[k])
    );
  end

  logic [WIDTH-1:0] s1_g, s1_p;
  logic [NGRP-1:0]  s1_gg, s1_gp;
  logic             s1_c0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_g  <= g_in;
      s1_p  <= p_in;
      s1_gg <= gg_in;
      s1_gp <= gp_in;
      s1_c0 <= c0_in;
    end
  end

  // Stage 2: each group carry is a flat sum of products of G/P and c0
  logic [NGRP:0] cg;
  logic          acc, prod;

  always_comb begin
    cg    = '0;
    acc   = 1'b0;
    prod  = 1'b0;
    cg[0] = s1_c0;
    for (int k = 0; k < NGRP; k++) begin
      acc  = s1_gg[k];
      prod = s1_gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prod & s1_gg[j]);
        prod = prod & s1_gp[j];
      end
      cg[k+1] = acc | (prod & s1_c0);
    end
  end

  logic [WIDTH-1:0]     carry_in;
  logic [NGRP-1:0][3:1] c_grp;
  logic [NGRP-1:0]      unused_s2_c4, unused_s2_g, unused_s2_p;

  for (genvar k = 0; k < NGRP; k++) begin : g_s2
    logic [4:1] c_loc;
    cla4_unit u_cla4 (
      .g     (s1_g[GRP*k +: GRP]),
      .p     (s1_p[GRP*k +: GRP]),
      .cin   (cg[k]),
      .c     (c_loc),
      .grp_g (unused_s2_g[k]),
      .grp_p (unused_s2_p[k])
    );
    assign c_grp[k]        = c_loc[3:1];
    assign unused_s2_c4[k] = c_loc[4];
    assign carry_in[GRP*k +: GRP] = {c_grp[k], cg[k]};
  end

  logic [WIDTH-1:0] sum_nx;
  assign sum_nx = s1_p ^ carry_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_nx;
        cout <= cg[NGRP];
        ovf  <= carry_in[WIDTH-1] ^ cg[NGRP];
        zero <= ~|sum_nx;
      end
    end
  end

endmodule
